// File: rtl/float10_pkg.sv
// Float10 format constants, driver state encoding and fixed<->float10 conversions.
package float10_pkg;

    localparam int unsigned FIX_W    = 12;
    localparam int unsigned F10_W    = 10;
    localparam int unsigned SIGN_BIT = 9;
    localparam int unsigned EXP_MSB  = 8;
    localparam int unsigned EXP_LSB  = 5;
    localparam int unsigned EXP_W    = 4;
    localparam int unsigned MAN_W    = 5;
    localparam int unsigned BIAS     = 7;

    localparam logic [FIX_W-1:0] SAT_POS = 12'h7FF;
    localparam logic [FIX_W-1:0] SAT_NEG = 12'h800;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ENCODE,
        ST_KICK,
        ST_WAIT,
        ST_DECODE,
        ST_HOLD
    } drv_state_t;

    // Magnitudes below 1<<MAN_W have no full mantissa and flush to zero.
    function automatic logic [F10_W-1:0] f10_encode(input logic [FIX_W-1:0] x);
        logic [FIX_W-1:0] mag;
        logic [EXP_W-1:0] p;
        logic [MAN_W-1:0] man;
        logic [F10_W-1:0] res;
        mag = x[FIX_W-1] ? (~x + FIX_W'(1)) : x;
        p   = '0;
        for (int i = 0; i < int'(FIX_W); i++) begin
            if (mag[i]) p = EXP_W'(i);
        end
        man = '0;
        res = '0;
        if (mag >= FIX_W'(32)) begin
            man = MAN_W'(mag >> (32'(p) - MAN_W));
            res = {x[FIX_W-1], EXP_W'(32'(p) + BIAS - (FIX_W - 1)), man};
        end
        return res;
    endfunction

    function automatic logic [FIX_W-1:0] f10_decode(input logic [F10_W-1:0] f);
        logic [EXP_W-1:0] e;
        logic [23:0]      mag;
        logic [FIX_W-1:0] lo;
        logic [FIX_W-1:0] res;
        e   = f[EXP_MSB:EXP_LSB];
        mag = '0;
        if (e != '0) mag = 24'({1'b1, f[MAN_W-1:0]}) << (32'(e) + (FIX_W - 1) - BIAS - MAN_W);
        lo  = mag[FIX_W-1:0];
        if (e == '0)
            res = '0;
        else if (!f[SIGN_BIT])
            res = (mag > 24'(SAT_POS)) ? SAT_POS : lo;
        else
            res = (mag > 24'(SAT_NEG)) ? SAT_NEG : (~lo + FIX_W'(1));
        return res;
    endfunction

endpackage

// File: rtl/float10_codec.sv
// Stateless fixed-point <-> float10 converter pair.
module float10_codec
    import float10_pkg::*;
(
    input  logic [FIX_W-1:0] i_fix,
    output logic [F10_W-1:0] o_f10_c,
    input  logic [F10_W-1:0] i_f10,
    output logic [FIX_W-1:0] o_fix_c
);

    assign o_f10_c = f10_encode(i_fix);
    assign o_fix_c = f10_decode(i_f10);

endmodule

// File: rtl/fir_stream_driver.sv
// Stream front/back end for a float10 FIR: encode, start filter, await completion edge, decode.
module fir_stream_driver
    import float10_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned EN_CYCLES = 2
) (
    input  logic             i_clk_fast,
    input  logic             i_rst,
    input  logic [FIX_W-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_flush,
    output logic             o_fir_en,
    output logic             o_fir_clr,
    output logic [F10_W-1:0] o_fir_in,
    input  logic [F10_W-1:0] i_fir_out,
    input  logic             i_fir_out_avl,
    output logic [FIX_W-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_timeout_err
);

    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned EN_W = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

    drv_state_t       r_state;
    logic [FIX_W-1:0] r_sample;
    logic [F10_W-1:0] r_fir_in;
    logic [F10_W-1:0] r_fir_out;
    logic [FIX_W-1:0] r_out_data;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_fir_en;
    logic             r_fir_clr;
    logic             r_timeout_err;
    logic             r_armed;
    logic [TO_W-1:0]  r_to_cnt;
    logic [EN_W-1:0]  r_en_cnt;
    logic [F10_W-1:0] w_enc;
    logic [FIX_W-1:0] w_dec;

    float10_codec u_codec (
        .i_fix   (r_sample),
        .o_f10_c (w_enc),
        .i_f10   (r_fir_out),
        .o_fix_c (w_dec)
    );

    // Outputs are set on the transition into the state that owns them.
    always_ff @(posedge i_clk_fast) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_sample      <= '0;
            r_fir_in      <= '0;
            r_fir_out     <= '0;
            r_out_data    <= '0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_fir_en      <= 1'b0;
            r_fir_clr     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_armed       <= 1'b0;
            r_to_cnt      <= '0;
            r_en_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_flush) begin
                        r_fir_clr  <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_CLEAR;
                    end else if (i_in_valid && r_in_ready) begin
                        r_sample   <= i_in_data;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_ENCODE;
                    end
                end
                ST_CLEAR: begin
                    r_fir_clr  <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                ST_ENCODE: begin
                    r_fir_in <= w_enc;
                    r_fir_en <= 1'b1;
                    r_en_cnt <= '0;
                    r_state  <= ST_KICK;
                end
                ST_KICK: begin
                    r_to_cnt <= '0;
                    r_armed  <= 1'b0;
                    if (r_en_cnt == EN_W'(EN_CYCLES - 1)) begin
                        r_fir_en <= 1'b0;
                        r_state  <= ST_WAIT;
                    end else begin
                        r_en_cnt <= r_en_cnt + EN_W'(1);
                    end
                end
                // A stale high level must drop (arm) before a high counts as completion.
                ST_WAIT: begin
                    if (r_armed && i_fir_out_avl) begin
                        r_fir_out <= i_fir_out;
                        r_state   <= ST_DECODE;
                    end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_in_ready    <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                        if (!i_fir_out_avl) r_armed <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    r_out_data  <= w_dec;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_fir_en    <= 1'b0;
                    r_fir_clr   <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_out_valid   = r_out_valid;
    assign o_fir_en      = r_fir_en;
    assign o_fir_clr     = r_fir_clr;
    assign o_fir_in      = r_fir_in;
    assign o_out_data    = r_out_data;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed bench for fir_stream_driver with a hand-driven filter completion interface.
module tb_fir_stream_driver;

    logic        clk;
    logic        rst;
    logic [11:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        fir_en;
    logic        fir_clr;
    logic [9:0]  fir_in;
    logic [9:0]  fir_out;
    logic        fir_out_avl;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    fir_stream_driver #(.TIMEOUT(1024), .EN_CYCLES(2)) dut (
        .i_clk_fast    (clk),
        .i_rst         (rst),
        .i_in_data     (in_data),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_flush       (flush),
        .o_fir_en      (fir_en),
        .o_fir_clr     (fir_clr),
        .o_fir_in      (fir_in),
        .i_fir_out     (fir_out),
        .i_fir_out_avl (fir_out_avl),
        .o_out_data    (out_data),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Offer one sample; returns on the negedge after the handshake edge.
    task automatic accept(input logic [11:0] din);
        in_data  = din;
        in_valid = 1'b1;
        step();
        check("in_ready_busy", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
    endtask

    // Checks fir_en arrives 2 clocks after handshake and lasts EN_CYCLES; ends with fir_en low.
    task automatic kick_check(input logic [9:0] exp_fin);
        int n;
        step();
        check("fir_en_latency", 32'(fir_en), 32'd1);
        check("fir_in", 32'(fir_in), 32'(exp_fin));
        n = 0;
        while (fir_en && n < 16) begin
            n++;
            step();
        end
        check("fir_en_cycles", 32'(n), 32'd2);
    endtask

    // Filter raises avl one edge into WAIT; output must appear 2 clocks after the rise.
    task automatic complete(input logic [9:0] fout, input logic [11:0] exp_out);
        step();
        fir_out     = fout;
        fir_out_avl = 1'b1;
        step();
        check("out_valid_early", 32'(out_valid), 32'd0);
        step();
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_data", 32'(out_data), 32'(exp_out));
        out_ready = 1'b1;
        step();
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
        out_ready   = 1'b0;
        fir_out_avl = 1'b0;
    endtask

    initial begin
        int  seen;
        rst         = 1'b1;
        in_data     = '0;
        in_valid    = 1'b0;
        flush       = 1'b0;
        fir_out     = '0;
        fir_out_avl = 1'b0;
        out_ready   = 1'b0;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fir_en", 32'(fir_en), 32'd0);
        check("rst_fir_clr", 32'(fir_clr), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_fir_in", 32'(fir_in), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        step();

        // Encode / decode vectors (input, expected fir_in, filter result, expected out_data).
        accept(12'h400); kick_check(10'h0C0); complete(10'h0C0, 12'h400);
        accept(12'h800); kick_check(10'h2E0); complete(10'h100, 12'h7FF);
        accept(12'h010); kick_check(10'h000); complete(10'h000, 12'h000);
        accept(12'hC00); kick_check(10'h2C0); complete(10'h300, 12'h800);
        accept(12'hF9C); kick_check(10'h252); complete(10'h2E0, 12'h800);
        accept(12'h123); kick_check(10'h084); complete(10'h200, 12'h000);
        accept(12'h7FF); kick_check(10'h0DF); complete(10'h0A5, 12'h250);
        accept(12'h020); kick_check(10'h020); complete(10'h2A5, 12'hDB0);

        // Stale high level through KICK; flush while busy must be ignored.
        fir_out     = 10'h100;
        fir_out_avl = 1'b1;
        accept(12'h400);
        kick_check(10'h0C0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy_ignored", 32'(fir_clr), 32'd0);
        step();
        check("stale_no_capture", 32'(out_valid), 32'd0);
        fir_out_avl = 1'b0;
        step(); step(); step();
        fir_out     = 10'h0C0;
        fir_out_avl = 1'b1;
        step();
        check("stale_valid_early", 32'(out_valid), 32'd0);
        step();
        check("stale_valid", 32'(out_valid), 32'd1);
        check("stale_data", 32'(out_data), 32'h400);
        out_ready = 1'b1;
        step();
        out_ready   = 1'b0;
        fir_out_avl = 1'b0;
        check("stale_done", 32'(in_ready), 32'd1);

        // Backpressure: output held while consumer stalls.
        accept(12'h7FF);
        kick_check(10'h0DF);
        step();
        fir_out     = 10'h0A5;
        fir_out_avl = 1'b1;
        step();
        step();
        check("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_data_stable", 32'(out_data), 32'h250);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_valid_held", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready   = 1'b0;
        fir_out_avl = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);

        // Flush and in_valid together: clear first, accept on the next IDLE cycle.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 12'h400;
        step();
        flush = 1'b0;
        check("flush_clr", 32'(fir_clr), 32'd1);
        check("flush_not_ready", 32'(in_ready), 32'd0);
        step();
        check("flush_clr_once", 32'(fir_clr), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("flush_accept", 32'(in_ready), 32'd0);
        check("flush_no_second_clr", 32'(fir_clr), 32'd0);
        kick_check(10'h0C0);
        complete(10'h0C0, 12'h400);

        // Timeout: completion never arrives.
        accept(12'h400);
        kick_check(10'h0C0);
        seen = 0;
        for (int i = 0; i < 1023; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("to_not_yet", 32'(timeout_err), 32'd0);
        check("to_still_busy", 32'(in_ready), 32'd0);
        step();
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_in_ready", 32'(in_ready), 32'd1);
        check("to_no_output", 32'(seen), 32'd0);
        check("to_out_valid", 32'(out_valid), 32'd0);

        // Sticky error survives a normal sample.
        accept(12'hC00); kick_check(10'h2C0); complete(10'h2C0, 12'hC00);
        check("to_sticky", 32'(timeout_err), 32'd1);

        // Reset mid-operation during KICK.
        accept(12'h400);
        step();
        check("mid_kick", 32'(fir_en), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_fir_en", 32'(fir_en), 32'd0);
        check("mid_rst_clr", 32'(fir_clr), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_err", 32'(timeout_err), 32'd0);
        step();
        accept(12'h123); kick_check(10'h084); complete(10'h0A5, 12'h250);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
